// File: rtl/rns_reg_file_sb.sv
// rns_reg_file_sb: two-bank register file (integer + RNS) with a sequenced
// post-reset clear, optional write-to-read forwarding and a per-register
// pending scoreboard used by decode to track in-flight destinations.
module rns_reg_file_sb #(
  parameter int NUM_DOMAINS = 2,
  parameter int DATA_W      = 8,
  parameter int REG_COUNT   = 8,
  parameter int BYPASS      = 1,
  localparam int ADDR_W     = $clog2(REG_COUNT),
  localparam int TOT_W      = NUM_DOMAINS * DATA_W,
  localparam int CNT_W      = $clog2(2 * REG_COUNT + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W:0]   wr_addr,
  input  logic [TOT_W-1:0]  wr_data,
  input  logic [ADDR_W:0]   rd_addr1,
  input  logic [ADDR_W:0]   rd_addr2,
  input  logic [ADDR_W-1:0] rd_addr3,
  input  logic              rsv_en,
  input  logic [ADDR_W:0]   rsv_addr,
  output logic [TOT_W-1:0]  rd_data1,
  output logic [TOT_W-1:0]  rd_data2,
  output logic [DATA_W-1:0] rd_data3,
  output logic              rd_pend1,
  output logic              rd_pend2,
  output logic [CNT_W-1:0]  pend_count,
  output logic              ready
);

  typedef enum logic [0:0] {ST_CLEAR = 1'b0, ST_READY = 1'b1} state_t;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(REG_COUNT - 1);

  state_t                  state_r;
  logic [ADDR_W-1:0]       clr_idx_r;
  logic                    ready_r;
  logic [2*REG_COUNT-1:0]  pend_r;
  logic [2*REG_COUNT-1:0]  pend_next_s;
  logic [CNT_W-1:0]        pend_count_r;
  logic [CNT_W-1:0]        pend_count_next_s;
  logic                    inc_s;
  logic                    dec_s;
  logic                    wr_act_s;
  logic                    rsv_act_s;
  logic [DATA_W-1:0]       int_mem_r [REG_COUNT];
  logic [TOT_W-1:0]        rns_mem_r [REG_COUNT];
  logic [TOT_W-1:0]        rd1_s;
  logic [TOT_W-1:0]        rd2_s;
  logic [DATA_W-1:0]       rd3_s;
  logic                    pend1_s;
  logic                    pend2_s;

  // Integer entries are presented zero-extended on the wide read ports.
  function automatic logic [TOT_W-1:0] zext(input logic [DATA_W-1:0] v);
    logic [TOT_W-1:0] r;
    r = '0;
    r[DATA_W-1:0] = v;
    return r;
  endfunction

  // Writes and reserves only take effect once the clear sequence is done.
  assign wr_act_s  = wr_en & ready_r;
  assign rsv_act_s = rsv_en & ready_r;

  // Clear/ready sequencer: walk every index once after reset, then stay ready.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= ST_CLEAR;
      clr_idx_r <= '0;
      ready_r   <= 1'b0;
    end else begin
      case (state_r)
        ST_CLEAR: begin
          clr_idx_r <= clr_idx_r + ADDR_W'(1);
          if (clr_idx_r == LAST_IDX) begin
            state_r <= ST_READY;
            ready_r <= 1'b1;
          end
        end
        ST_READY: begin
          ready_r <= 1'b1;
        end
        default: begin
          state_r   <= ST_CLEAR;
          clr_idx_r <= '0;
          ready_r   <= 1'b0;
        end
      endcase
    end
  end

  // Storage update: zero one entry per bank while clearing, else accept writes.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state_r == ST_CLEAR) begin
        int_mem_r[clr_idx_r] <= '0;
        rns_mem_r[clr_idx_r] <= '0;
      end else if (wr_act_s) begin
        if (wr_addr[ADDR_W]) begin
          rns_mem_r[wr_addr[ADDR_W-1:0]] <= wr_data;
        end else begin
          int_mem_r[wr_addr[ADDR_W-1:0]] <= wr_data[DATA_W-1:0];
        end
      end
    end
  end

  // Scoreboard next state: a same-address reserve beats the clearing write.
  always_comb begin
    pend_next_s = pend_r;
    inc_s       = 1'b0;
    dec_s       = 1'b0;
    if (wr_act_s) begin
      pend_next_s[wr_addr] = 1'b0;
      dec_s = pend_r[wr_addr] & ~(rsv_act_s & (rsv_addr == wr_addr));
    end else begin
      dec_s = 1'b0;
    end
    if (rsv_act_s) begin
      pend_next_s[rsv_addr] = 1'b1;
      inc_s = ~pend_r[rsv_addr];
    end else begin
      inc_s = 1'b0;
    end
    pend_count_next_s = pend_count_r + CNT_W'(inc_s) - CNT_W'(dec_s);
  end

  // Scoreboard registers: bits and population count move on the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      pend_r       <= '0;
      pend_count_r <= '0;
    end else begin
      pend_r       <= pend_next_s;
      pend_count_r <= pend_count_next_s;
    end
  end

  // Read ports: stored value, optionally overridden by a same-cycle write.
  always_comb begin
    rd1_s   = '0;
    rd2_s   = '0;
    rd3_s   = '0;
    pend1_s = 1'b0;
    pend2_s = 1'b0;
    if (ready_r) begin
      rd1_s   = rd_addr1[ADDR_W] ? rns_mem_r[rd_addr1[ADDR_W-1:0]]
                                 : zext(int_mem_r[rd_addr1[ADDR_W-1:0]]);
      rd2_s   = rd_addr2[ADDR_W] ? rns_mem_r[rd_addr2[ADDR_W-1:0]]
                                 : zext(int_mem_r[rd_addr2[ADDR_W-1:0]]);
      rd3_s   = int_mem_r[rd_addr3];
      pend1_s = pend_r[rd_addr1];
      pend2_s = pend_r[rd_addr2];
      if ((BYPASS != 0) && wr_en && (wr_addr == rd_addr1)) begin
        rd1_s   = wr_addr[ADDR_W] ? wr_data : zext(wr_data[DATA_W-1:0]);
        pend1_s = rsv_en & (rsv_addr == wr_addr);
      end else begin
        pend1_s = pend_r[rd_addr1];
      end
      if ((BYPASS != 0) && wr_en && (wr_addr == rd_addr2)) begin
        rd2_s   = wr_addr[ADDR_W] ? wr_data : zext(wr_data[DATA_W-1:0]);
        pend2_s = rsv_en & (rsv_addr == wr_addr);
      end else begin
        pend2_s = pend_r[rd_addr2];
      end
      if ((BYPASS != 0) && wr_en && (wr_addr == {1'b0, rd_addr3})) begin
        rd3_s = wr_data[DATA_W-1:0];
      end else begin
        rd3_s = int_mem_r[rd_addr3];
      end
    end else begin
      rd1_s = '0;
    end
  end

  assign rd_data1   = rd1_s;
  assign rd_data2   = rd2_s;
  assign rd_data3   = rd3_s;
  assign rd_pend1   = pend1_s;
  assign rd_pend2   = pend2_s;
  assign pend_count = pend_count_r;
  assign ready      = ready_r;

endmodule

// File: tb/tb_rns_reg_file_sb.sv
// tb_rns_reg_file_sb: directed vectors against a forwarding instance and a
// non-forwarding instance driven with identical stimulus.
module tb_rns_reg_file_sb;

  logic        clk = 1'b0;
  logic        reset;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [15:0] wr_data;
  logic [3:0]  rd_addr1;
  logic [3:0]  rd_addr2;
  logic [2:0]  rd_addr3;
  logic        rsv_en;
  logic [3:0]  rsv_addr;

  logic [15:0] b_rd1, b_rd2, n_rd1, n_rd2;
  logic [7:0]  b_rd3, n_rd3;
  logic        b_p1, b_p2, n_p1, n_p2;
  logic [4:0]  b_cnt, n_cnt;
  logic        b_rdy, n_rdy;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  rns_reg_file_sb #(.NUM_DOMAINS(2), .DATA_W(8), .REG_COUNT(8), .BYPASS(1)) dut_byp (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr1(rd_addr1), .rd_addr2(rd_addr2), .rd_addr3(rd_addr3),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr),
    .rd_data1(b_rd1), .rd_data2(b_rd2), .rd_data3(b_rd3),
    .rd_pend1(b_p1), .rd_pend2(b_p2), .pend_count(b_cnt), .ready(b_rdy));

  rns_reg_file_sb #(.NUM_DOMAINS(2), .DATA_W(8), .REG_COUNT(8), .BYPASS(0)) dut_nb (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr1(rd_addr1), .rd_addr2(rd_addr2), .rd_addr3(rd_addr3),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr),
    .rd_data1(n_rd1), .rd_data2(n_rd2), .rd_data3(n_rd3),
    .rd_pend1(n_p1), .rd_pend2(n_p2), .pend_count(n_cnt), .ready(n_rdy));

  typedef struct {
    logic        we;
    logic [3:0]  wa;
    logic [15:0] wd;
    logic        re;
    logic [3:0]  ra;
    logic [3:0]  a1;
    logic [3:0]  a2;
    logic [2:0]  a3;
    logic [15:0] e1;
    logic [15:0] e2;
    logic [7:0]  e3;
    logic        p1;
    logic        p2;
    logic [4:0]  ec;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic we, input logic [3:0] wa, input logic [15:0] wd,
                     input logic re, input logic [3:0] ra,
                     input logic [3:0] a1, input logic [3:0] a2, input logic [2:0] a3,
                     input logic [15:0] e1, input logic [15:0] e2, input logic [7:0] e3,
                     input logic p1, input logic p2, input logic [4:0] ec);
    vec_t v;
    v.we = we; v.wa = wa; v.wd = wd; v.re = re; v.ra = ra;
    v.a1 = a1; v.a2 = a2; v.a3 = a3;
    v.e1 = e1; v.e2 = e2; v.e3 = e3; v.p1 = p1; v.p2 = p2; v.ec = ec;
    vecs.push_back(v);
  endtask

  initial begin
    // Expected values are for the forwarding instance, sampled before the edge;
    // ec is pend_count after the edge.
    //  we  wa       wd        re  ra       a1       a2       a3    e1        e2        e3     p1    p2    ec
    add(1'b1, 4'b1011, 16'hA5C3, 1'b0, 4'b0000, 4'b1011, 4'b0011, 3'd2, 16'hA5C3, 16'h0000, 8'h00, 1'b0, 1'b0, 5'd0);
    add(1'b1, 4'b0011, 16'hFF7E, 1'b0, 4'b0000, 4'b1011, 4'b0011, 3'd3, 16'hA5C3, 16'h007E, 8'h7E, 1'b0, 1'b0, 5'd0);
    add(1'b0, 4'b0000, 16'h0000, 1'b0, 4'b0000, 4'b1011, 4'b0011, 3'd3, 16'hA5C3, 16'h007E, 8'h7E, 1'b0, 1'b0, 5'd0);
    add(1'b0, 4'b0000, 16'h0000, 1'b1, 4'b0001, 4'b0001, 4'b1001, 3'd3, 16'h0000, 16'h0000, 8'h7E, 1'b0, 1'b0, 5'd1);
    add(1'b0, 4'b0000, 16'h0000, 1'b1, 4'b1001, 4'b0001, 4'b1001, 3'd3, 16'h0000, 16'h0000, 8'h7E, 1'b1, 1'b0, 5'd2);
    add(1'b0, 4'b0000, 16'h0000, 1'b1, 4'b0001, 4'b0001, 4'b1001, 3'd3, 16'h0000, 16'h0000, 8'h7E, 1'b1, 1'b1, 5'd2);
    add(1'b1, 4'b1001, 16'h1234, 1'b0, 4'b0000, 4'b1001, 4'b0001, 3'd3, 16'h1234, 16'h0000, 8'h7E, 1'b0, 1'b1, 5'd1);
    add(1'b1, 4'b0101, 16'h00AA, 1'b0, 4'b0000, 4'b1001, 4'b0101, 3'd5, 16'h1234, 16'h00AA, 8'hAA, 1'b0, 1'b0, 5'd1);
    add(1'b0, 4'b0000, 16'h0000, 1'b1, 4'b0010, 4'b0010, 4'b1010, 3'd3, 16'h0000, 16'h0000, 8'h7E, 1'b0, 1'b0, 5'd2);
    add(1'b1, 4'b0010, 16'h0033, 1'b1, 4'b0010, 4'b0010, 4'b0001, 3'd3, 16'h0033, 16'h0000, 8'h7E, 1'b1, 1'b1, 5'd2);
    add(1'b0, 4'b0000, 16'h0000, 1'b0, 4'b0000, 4'b0010, 4'b1010, 3'd3, 16'h0033, 16'h0000, 8'h7E, 1'b1, 1'b0, 5'd2);
    add(1'b1, 4'b0001, 16'h0044, 1'b1, 4'b0110, 4'b0001, 4'b0110, 3'd3, 16'h0044, 16'h0000, 8'h7E, 1'b0, 1'b0, 5'd2);
    add(1'b0, 4'b0000, 16'h0000, 1'b0, 4'b0000, 4'b0001, 4'b0110, 3'd3, 16'h0044, 16'h0000, 8'h7E, 1'b0, 1'b1, 5'd2);

    reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    rd_addr1 = 4'b1011; rd_addr2 = 4'b0000; rd_addr3 = 3'd2;
    rsv_en = 1'b0; rsv_addr = '0;

    // Reset held, then the clear sequence with ignored write/reserve.
    repeat (3) tick();
    chk("reset ready", {31'd0, b_rdy}, 32'd0);
    chk("reset count", {27'd0, b_cnt}, 32'd0);
    chk("reset rd1", {16'd0, b_rd1}, 32'd0);
    reset = 1'b0;
    rd_addr1 = 4'b0010;
    for (int i = 0; i < 8; i++) begin
      wr_en = (i == 2); wr_addr = 4'b0010; wr_data = 16'h0055;
      rsv_en = (i == 2); rsv_addr = 4'b0010;
      #1;
      chk($sformatf("clear%0d ready", i), {31'd0, b_rdy}, 32'd0);
      chk($sformatf("clear%0d rd1", i), {16'd0, b_rd1}, 32'd0);
      chk($sformatf("clear%0d pend1", i), {31'd0, b_p1}, 32'd0);
      tick();
    end
    wr_en = 1'b0; rsv_en = 1'b0;
    chk("ready after 8", {31'd0, b_rdy}, 32'd1);
    chk("count after clear", {27'd0, b_cnt}, 32'd0);

    // Vector table.
    foreach (vecs[i]) begin
      wr_en = vecs[i].we; wr_addr = vecs[i].wa; wr_data = vecs[i].wd;
      rsv_en = vecs[i].re; rsv_addr = vecs[i].ra;
      rd_addr1 = vecs[i].a1; rd_addr2 = vecs[i].a2; rd_addr3 = vecs[i].a3;
      #1;
      chk($sformatf("v%0d rd1", i), {16'd0, b_rd1}, {16'd0, vecs[i].e1});
      chk($sformatf("v%0d rd2", i), {16'd0, b_rd2}, {16'd0, vecs[i].e2});
      chk($sformatf("v%0d rd3", i), {24'd0, b_rd3}, {24'd0, vecs[i].e3});
      chk($sformatf("v%0d pend1", i), {31'd0, b_p1}, {31'd0, vecs[i].p1});
      chk($sformatf("v%0d pend2", i), {31'd0, b_p2}, {31'd0, vecs[i].p2});
      tick();
      chk($sformatf("v%0d count", i), {27'd0, b_cnt}, {27'd0, vecs[i].ec});
      chk($sformatf("v%0d nb count", i), {27'd0, n_cnt}, {27'd0, vecs[i].ec});
    end
    wr_en = 1'b0; rsv_en = 1'b0;

    // Forwarding vs. stored-only read in the write cycle.
    wr_en = 1'b1; wr_addr = 4'b1110; wr_data = 16'hBEEF; rd_addr1 = 4'b1110;
    #1;
    chk("byp same-cycle", {16'd0, b_rd1}, 32'h0000BEEF);
    chk("nobyp same-cycle", {16'd0, n_rd1}, 32'h00000000);
    tick();
    wr_en = 1'b0;
    #1;
    chk("nobyp next-cycle", {16'd0, n_rd1}, 32'h0000BEEF);

    // Build up five pending registers and int[0]=8'h11.
    wr_en = 1'b1; wr_addr = 4'b0000; wr_data = 16'h0011;
    rsv_en = 1'b1; rsv_addr = 4'b1000;
    tick();
    wr_en = 1'b0; rsv_addr = 4'b1111;
    tick();
    rsv_addr = 4'b0111;
    tick();
    rsv_en = 1'b0; rd_addr3 = 3'd0; rd_addr1 = 4'b1000;
    #1;
    chk("five pending", {27'd0, b_cnt}, 32'd5);
    chk("int0 before reset", {24'd0, b_rd3}, 32'h11);
    chk("pend 1000", {31'd0, b_p1}, 32'd1);

    // Reset, partial clear, reset again, full clear.
    reset = 1'b1;
    tick();
    chk("mid reset count", {27'd0, b_cnt}, 32'd0);
    chk("mid reset ready", {31'd0, b_rdy}, 32'd0);
    reset = 1'b0;
    repeat (4) tick();
    chk("partial clear ready", {31'd0, b_rdy}, 32'd0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      #1;
      chk($sformatf("reclear%0d ready", i), {31'd0, b_rdy}, 32'd0);
      tick();
    end
    chk("reclear ready", {31'd0, b_rdy}, 32'd1);
    chk("reclear count", {27'd0, b_cnt}, 32'd0);
    chk("reclear int0", {24'd0, b_rd3}, 32'd0);
    chk("reclear pend 1000", {31'd0, b_p1}, 32'd0);
    rd_addr1 = 4'b1011;
    #1;
    chk("reclear rns3", {16'd0, b_rd1}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
